// File: rtl/nios_mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : nios_mul_iter_unit
// Purpose  : Iterative DATA_W x DATA_W multiplier returning either the low
//            word (MUL) or the high word (MULXSS / MULXSU / MULXUU) of the
//            product. One registered LANE_W x LANE_W unsigned lane is reused
//            over several cycles, and the partial products are summed in a
//            2*DATA_W accumulator.
// Ports    : clk, reset_n (async, active low)
//            in_valid/in_ready   request handshake, in_mode, in_src1, in_src2
//            out_valid/out_ready result handshake, out_result
// Revision : 1.0 - initial release
// ============================================================================
module nios_mul_iter_unit #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int N     = DATA_W / LANE_W;
  localparam int CW    = $clog2(N) + 1;   // also wide enough for i+j
  localparam int ACC_W = 2 * DATA_W;
  localparam int PW    = 2 * LANE_W;

  localparam logic [1:0] C_MODE_MUL    = 2'b00;
  localparam logic [1:0] C_MODE_MULXSS = 2'b01;
  localparam logic [1:0] C_MODE_MULXSU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FIX   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_a_mag;
  logic [DATA_W-1:0] r_b_mag;
  logic              r_neg;
  logic [CW-1:0]     r_i;
  logic [CW-1:0]     r_j;
  logic [PW-1:0]     r_prod;
  logic              r_prod_vld;
  logic [CW-1:0]     r_prod_pos;   // i+j of the product held in r_prod
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_result;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [CW-1:0]     w_jmax;
  logic              w_last;
  logic [LANE_W-1:0] w_a_lane;
  logic [LANE_W-1:0] w_b_lane;
  logic [ACC_W-1:0]  w_pp;
  logic [ACC_W-1:0]  w_fin;

  // Only MULXSS/MULXSU treat A as signed; only MULXSS treats B as signed.
  assign w_a_neg = ((in_mode == C_MODE_MULXSS) || (in_mode == C_MODE_MULXSU))
                   && in_src1[DATA_W-1];
  assign w_b_neg = (in_mode == C_MODE_MULXSS) && in_src2[DATA_W-1];

  // The low word only needs pairs with i+j < N, so row i stops at N-1-i.
  assign w_jmax = (r_mode == C_MODE_MUL) ? (CW'(N - 1) - r_i) : CW'(N - 1);
  assign w_last = (r_i == CW'(N - 1)) && (r_j == w_jmax);

  assign w_a_lane = LANE_W'(r_a_mag >> (32'(r_i) * LANE_W));
  assign w_b_lane = LANE_W'(r_b_mag >> (32'(r_j) * LANE_W));

  assign w_pp  = ACC_W'(r_prod) << (32'(r_prod_pos) * LANE_W);
  assign w_fin = r_neg ? (ACC_W'(0) - r_acc) : r_acc;

  assign out_result = r_result;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_FIX;
      S_FIX:   w_next = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 2'b00;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_neg      <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_prod_pos <= '0;
      r_acc      <= '0;
      r_result   <= '0;
    end else begin
      r_prod_vld <= 1'b0;
      // The product issued last cycle is folded in one cycle later; this
      // covers every ISSUE cycle after the first plus the DRAIN cycle.
      if (r_prod_vld) r_acc <= r_acc + w_pp;

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mode  <= in_mode;
            r_a_mag <= w_a_neg ? (DATA_W'(0) - in_src1) : in_src1;
            r_b_mag <= w_b_neg ? (DATA_W'(0) - in_src2) : in_src2;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
          end
        end
        S_ISSUE: begin
          r_prod     <= PW'(w_a_lane) * PW'(w_b_lane);
          r_prod_vld <= 1'b1;
          r_prod_pos <= r_i + r_j;
          if (r_j == w_jmax) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_FIX: begin
          r_result <= (r_mode == C_MODE_MUL) ? w_fin[DATA_W-1:0]
                                             : w_fin[ACC_W-1:DATA_W];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_mul_iter_unit
// Purpose  : Directed testbench for nios_mul_iter_unit at DATA_W = 16, 32, 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_mul_iter_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  wire  [2:0]  irdy;
  wire  [2:0]  ov;
  logic [1:0]  md;
  logic [63:0] sa;
  logic [63:0] sb;
  wire  [15:0] res16;
  wire  [31:0] res32;
  wire  [63:0] res64;

  int total = 0;
  int bad   = 0;

  nios_mul_iter_unit #(.DATA_W(16), .LANE_W(16)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_mode(md), .in_src1(sa[15:0]), .in_src2(sb[15:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(res16));

  nios_mul_iter_unit #(.DATA_W(32), .LANE_W(16)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_mode(md), .in_src1(sa[31:0]), .in_src2(sb[31:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_result(res32));

  nios_mul_iter_unit #(.DATA_W(64), .LANE_W(16)) u64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_mode(md), .in_src1(sa), .in_src2(sb),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_result(res64));

  function automatic logic [63:0] get_res(input int k);
    case (k)
      0:       return {48'd0, res16};
      1:       return {32'd0, res32};
      default: return res64;
    endcase
  endfunction

  // Reference: sign-extend to 128 bits and multiply directly.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] m,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  mask;
    logic [127:0] ea, eb, p;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ea = {64'd0, a & mask};
    eb = {64'd0, b & mask};
    if ((m == 2'b01 || m == 2'b10) && a[w-1]) ea = ea - (128'd1 << w);
    if ((m == 2'b01) && b[w-1])               eb = eb - (128'd1 << w);
    p = ea * eb;
    if (m == 2'b00) return p[63:0] & mask;
    p = p >> w;
    return p[63:0] & mask;
  endfunction

  function automatic int exp_lat(input int w, input logic [1:0] m);
    int n;
    n = w / 16;
    return ((m == 2'b00) ? (n * (n + 1) / 2) : (n * n)) + 2;
  endfunction

  // Issues one request on instance k and waits (bounded) for out_valid.
  // Operands and mode are scrambled right after acceptance.
  task automatic run_op(input int k, input logic [1:0] m, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] r,
                        output int lat, output int busy_viol);
    @(negedge clk);
    md = m; sa = a; sb = b; iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    md = ~m;
    sa = {$urandom, $urandom};
    sb = {$urandom, $urandom};
    lat = 0;
    busy_viol = 0;
    while (lat < 40) begin
      if (ov[k]) break;
      if (irdy[k]) busy_viol++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ov[k]) lat = -1;
    r = get_res(k);
  endtask

  task automatic consume(input int k);
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    iv = '0; ordy = '0; md = '0; sa = '0; sb = '0;
    repeat (3) @(negedge clk);
    total++; if (irdy !== 3'b111) begin bad++; $display("FAIL reset_in_ready: got %b want 111", irdy); end
    total++; if (ov !== 3'b000) begin bad++; $display("FAIL reset_out_valid: got %b want 000", ov); end
    total++; if (res16 !== 16'h0) begin bad++; $display("FAIL reset_res16: got %h want 0", res16); end
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL reset_res32: got %h want 0", res32); end
    total++; if (res64 !== 64'h0) begin bad++; $display("FAIL reset_res64: got %h want 0", res64); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mul32();
    logic [63:0] r;
    int lat, bv;
    total++; if (irdy[1] !== 1'b1) begin bad++; $display("FAIL mul32_idle_ready: got %b want 1", irdy[1]); end
    run_op(1, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat, bv);
    total++; if (r !== 64'h1) begin bad++; $display("FAIL mul32_result: got %h want 1", r); end
    total++; if (lat !== 5) begin bad++; $display("FAIL mul32_latency: got %0d want 5", lat); end
    total++; if (bv !== 0) begin bad++; $display("FAIL mul32_busy_ready: got %0d ready cycles want 0", bv); end
    consume(1);
    total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL mul32_consume_valid: got %b want 0", ov[1]); end
    total++; if (irdy[1] !== 1'b1) begin bad++; $display("FAIL mul32_consume_ready: got %b want 1", irdy[1]); end
  endtask

  task automatic test_high32();
    logic [1:0]  tm [8] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [31:0] ta [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                            32'h80000000, 32'h80000000, 32'h00010001, 32'hFFFFFFFE};
    logic [31:0] tb [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                            32'h80000000, 32'h80000000, 32'h00010001, 32'h00000003};
    logic [31:0] te [8] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h40000000,
                            32'hC0000000, 32'h40000000, 32'h00020001, 32'hFFFFFFFF};
    logic [63:0] r;
    int lat, bv, el;
    for (int t = 0; t < 8; t++) begin
      run_op(1, tm[t], {32'd0, ta[t]}, {32'd0, tb[t]}, r, lat, bv);
      el = (tm[t] == 2'b00) ? 5 : 6;
      total++; if (r !== {32'd0, te[t]}) begin bad++; $display("FAIL dir32_result[%0d]: got %h want %h", t, r, te[t]); end
      total++; if (lat !== el) begin bad++; $display("FAIL dir32_latency[%0d]: got %0d want %0d", t, lat, el); end
      consume(1);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    int lat, bv;
    run_op(1, 2'b11, 64'h2, 64'h8000_0000, r, lat, bv);
    total++; if (r !== 64'h1) begin bad++; $display("FAIL bp_result: got %h want 1", r); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      iv[1] = 1'b1; md = 2'b00; sa = {$urandom, $urandom}; sb = {$urandom, $urandom};
      @(posedge clk);
      #1;
      total++;
      if (ov[1] !== 1'b1 || res32 !== 32'h1 || irdy[1] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b result=%h ready=%b want 1/00000001/0",
                 c, ov[1], res32, irdy[1]);
      end
    end
    @(negedge clk);
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    ordy[1] = 1'b0;
    iv[1] = 1'b0;
    total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", ov[1]); end
    total++; if (irdy[1] !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", irdy[1]); end
    @(posedge clk);
    #1;
    total++; if (irdy[1] !== 1'b1) begin bad++; $display("FAIL bp_no_accept: got ready=%b want 1", irdy[1]); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    int lat, bv, seen;
    @(negedge clk);
    md = 2'b01; sa = 64'h1234_5678; sb = 64'h9ABC_DEF0; iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", ov[1]); end
    total++; if (irdy[1] !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", irdy[1]); end
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL rstmid_result: got %h want 0", res32); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov[1]) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_output: got %0d valid cycles want 0", seen); end
    run_op(1, 2'b00, 64'd3, 64'd5, r, lat, bv);
    total++; if (r !== 64'd15) begin bad++; $display("FAIL rstmid_next_result: got %h want f", r); end
    total++; if (lat !== 5) begin bad++; $display("FAIL rstmid_next_latency: got %0d want 5", lat); end
    consume(1);
  endtask

  task automatic test_sweep();
    logic [63:0] r, a, b, e, mask;
    int lat, bv, w, el;
    for (int k = 0; k < 3; k++) begin
      w = 16 << k;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      for (int m = 0; m < 4; m++) begin
        for (int v = 0; v < 4; v++) begin
          case (v)
            0:       begin a = mask;                 b = mask;       end
            1:       begin a = (64'd1 << (w - 1));   b = mask >> 1;  end
            default: begin a = {$urandom, $urandom} & mask; b = {$urandom, $urandom} & mask; end
          endcase
          e  = ref_mul(w, 2'(m), a, b);
          el = exp_lat(w, 2'(m));
          run_op(k, 2'(m), a, b, r, lat, bv);
          total++; if (r !== e) begin bad++; $display("FAIL sweep_result w=%0d m=%0d a=%h b=%h: got %h want %h", w, m, a, b, r, e); end
          total++; if (lat !== el) begin bad++; $display("FAIL sweep_latency w=%0d m=%0d: got %0d want %0d", w, m, lat, el); end
          consume(k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul32();
    test_high32();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios_mul_iter_unit.md
Name: nios_mul_iter_unit

Overview:
- Parametrised, iterative successor to the fixed 32-bit low-word multiply cell in the Nios II datapath.
- Computes the low word (MUL) or the high word (MULXSS / MULXSU / MULXUU) of a DATA_W x DATA_W product.
- Reuses one registered LANE_W x LANE_W unsigned multiplier over several cycles.
- Sits beside the ALU behind a valid/ready handshake, so the CPU stalls on it like any other multi-cycle unit.

Parameters:
- DATA_W, 32, operand and result width; must be a multiple of LANE_W, legal range 16..64.
- LANE_W, 16, width of the single hardware multiplier lane.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- in_mode  in  2  operation: 00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  DATA_W  selected result word

Behaviour:
- Definitions:
  - N = DATA_W/LANE_W.
  - Partial products are pp(i,j) = A_lane_i * B_lane_j, weighted by 2^((i+j)*LANE_W).
  - P is the number of partials issued per operation:
    - MUL: only pairs with i+j < N, so P = N(N+1)/2.
    - High-word modes: P = N*N.
- Reset: asynchronous on reset_n low. State=IDLE, in_ready=1, out_valid=0, out_result=0, accumulator=0, counters=0. Reset mid-operation abandons the operation with no output.
- FSM states: IDLE, ISSUE, DRAIN, FIX, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture the mode and the operand magnitudes. Sign rules:
    - MULXSS: both operands signed.
    - MULXSU: A signed, B unsigned.
    - MULXUU and MUL: both treated as unsigned; MUL low word is sign-independent.
  - Store neg = sign(A) XOR sign(B) over the signed operands only, then go to ISSUE.
- ISSUE:
  - One partial per cycle in row-major order (i outer, j inner), skipping pairs that are excluded in MUL.
  - The multiplier output is registered (1-cycle latency).
  - Each registered product is shifted and added into a 2*DATA_W accumulator on the following cycle.
  - After the P-th issue, go to DRAIN.
- DRAIN: accumulate the last product, then go to FIX.
- FIX:
  - If neg=1, accumulator becomes its two's complement (modulo 2^(2*DATA_W)).
  - out_result takes the low DATA_W bits for MUL and the high DATA_W bits otherwise.
  - out_valid=1; go to HOLD.
- HOLD:
  - out_valid and out_result stay stable until out_ready=1.
  - On that edge out_valid goes to 0, and the state goes to IDLE with in_ready=1 on the next cycle.
  - A new request therefore cannot be accepted in the same cycle the result is consumed.
- Latency: out_valid rises P+2 edges after the accepting edge.
  - DATA_W=32, MUL: 5 cycles.
  - DATA_W=32, high-word modes: 6 cycles.
- Handshake:
  - in_ready=0 in every state except IDLE; in_valid is ignored while busy.
  - out_ready is ignored while out_valid=0.
  - Operand or mode changes after acceptance have no effect.
- Arithmetic: all lane products are unsigned; no overflow flag. The MUL low word is exact modulo 2^DATA_W.

Test Plan:
- Reset and idle: hold reset_n=0 mid-ISSUE, release -> out_valid=0, in_ready=1, out_result=0, and the next request completes normally.
- MUL, DATA_W=32, A=0xFFFFFFFF, B=0xFFFFFFFF -> out_result=0x00000001 exactly 5 cycles after accept; in_ready=0 throughout.
- MULXUU, same operands -> out_result=0xFFFFFFFE after 6 cycles. MULXSS, same operands (-1 * -1) -> 0x00000000.
- MULXSU, A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) -> product 0xFFFFFFFF_00000001, out_result=0xFFFFFFFF. MULXSS, A=B=0x80000000 -> out_result=0x40000000.
- Backpressure: out_ready=0 for 10 cycles while out_valid=1 -> result stable and in_valid ignored. A single out_ready pulse -> out_valid drops, in_ready=1 on the next cycle.
- Parameter sweep: DATA_W=16 and 64 with random operands in all modes vs a reference model. Latency must equal P+2 (DATA_W=64: 12 for MUL, 18 for high-word modes).
